// File: rtl/search_mem_arbiter_pkg.sv
// Shared definitions for the search memory arbiter: parameter defaults,
// the one-hot FSM state encoding and a pointer-width helper.
package search_mem_arbiter_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int AW_DEFAULT   = 5;
    localparam int DW_DEFAULT   = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_ISSUE = 3'b010,
        S_DRAIN = 3'b100
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/search_mem_arbiter_rr_arbiter.sv
// Combinational winner selector: rotating priority starting after the
// pointer in round-robin mode, lowest index first in fixed-priority mode.
module rr_arbiter
    import search_mem_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    input  logic            mode_i,
    output logic [NREQ-1:0] winner_o
);

    logic found;
    int   idx;

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = mode_i ? k : (int'(ptr_i) + 1 + k) % NREQ;
            if (!found && req_i[idx]) begin
                winner_o[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/search_mem_arbiter.sv
// Shares one registered-read memory port among NREQ requesters: one grant per
// cycle, optional bus lock, and an in-flight tag that routes returning data.
module search_mem_arbiter
    import search_mem_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_ni,
    input  logic             mode_i,
    input  logic [NREQ-1:0]  req_i,
    input  logic [NREQ-1:0]  lock_i,
    input  logic [NREQ*AW-1:0] addr_in_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [NREQ-1:0]  rd_valid_o,
    output logic [DW-1:0]    rd_data_o,
    output logic [AW-1:0]    mem_addr_o,
    input  logic [DW-1:0]    mem_q_i,
    output logic             busy_o
);

    localparam int PW = ptr_width(NREQ);

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   ptr_q;
    logic [NREQ-1:0] gnt_q;
    logic            tag_vld_q;
    logic [PW-1:0]   tag_q;
    logic [NREQ-1:0] rd_valid_q;
    logic [AW-1:0]   mem_addr_q;
    logic            owner_vld_q;
    logic [PW-1:0]   owner_q;
    logic            busy_q;

    logic [NREQ-1:0] arb_win;
    logic [NREQ-1:0] gnt_d;
    logic [PW-1:0]   gnt_idx;
    logic [AW-1:0]   addr_sel;
    logic            any_req;
    logic            lock_hit;
    logic            any_gnt;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .mode_i   (mode_i),
        .winner_o (arb_win)
    );

    always_comb begin
        any_req  = |req_i;
        lock_hit = owner_vld_q && req_i[owner_q] && lock_i[owner_q];
        gnt_d    = '0;
        gnt_idx  = '0;
        // A locked owner that still requests keeps the port, in either mode.
        if (lock_hit) begin
            gnt_d[owner_q] = 1'b1;
        end else begin
            gnt_d = arb_win;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_d[i]) begin
                gnt_idx = PW'(i);
            end
        end
        any_gnt  = |gnt_d;
        addr_sel = addr_in_i[gnt_idx*AW +: AW];

        case (state_q)
            S_IDLE:  state_d = any_req ? S_ISSUE : S_IDLE;
            S_ISSUE: state_d = any_req ? S_ISSUE : S_DRAIN;
            S_DRAIN: state_d = any_req ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            ptr_q       <= PW'(NREQ - 1);
            gnt_q       <= '0;
            tag_vld_q   <= 1'b0;
            tag_q       <= '0;
            rd_valid_q  <= '0;
            mem_addr_q  <= '0;
            owner_vld_q <= 1'b0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            gnt_q       <= gnt_d;
            tag_vld_q   <= any_gnt;
            owner_vld_q <= any_gnt;

            rd_valid_q <= '0;
            if (tag_vld_q) begin
                rd_valid_q[tag_q] <= 1'b1;
            end

            if (any_gnt) begin
                tag_q      <= gnt_idx;
                owner_q    <= gnt_idx;
                mem_addr_q <= addr_sel;
            end

            // Only a genuine round-robin win moves the pointer.
            if (any_gnt && !lock_hit && !mode_i) begin
                ptr_q <= gnt_idx;
            end
        end
    end

    assign gnt_o      = gnt_q;
    assign rd_valid_o = rd_valid_q;
    assign mem_addr_o = mem_addr_q;
    assign busy_o     = busy_q;
    assign rd_data_o  = (|rd_valid_q) ? mem_q_i : '0;

endmodule

// File: doc/search_mem_arbiter.md
SEARCH_MEM_ARBITER -- requirements
Module: search_mem_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the memory read port.
REQ-002 Parameter AW, default 5, memory address width.
REQ-003 Parameter DW, default 8, memory data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 mode  input  1  0 = round-robin, 1 = fixed priority (index 0 highest).
REQ-007 req  input  NREQ  per-requester read request, level, held until granted.
REQ-008 lock  input  NREQ  per-requester bus lock; while asserted with req, requester keeps grant.
REQ-009 addr_in  input  NREQ*AW  packed addresses, slice i = addr_in[i*AW +: AW].
REQ-010 gnt  output  NREQ  one-hot, one-cycle pulse: requester i address launched this cycle.
REQ-011 rd_valid  output  NREQ  one-hot, one-cycle pulse: rd_data belongs to requester i.
REQ-012 rd_data  output  DW  read data, meaningful only while rd_valid nonzero.
REQ-013 mem_addr  output  AW  address driven to memory_block read port (registered).
REQ-014 mem_q  input  DW  memory_block output, valid one cycle after mem_addr registered.
REQ-015 busy  output  1  high while any read is in flight or any req is pending.

Function
REQ-016 At most one gnt bit high per cycle; grants are issued back-to-back, one per cycle, with no idle cycle between requesters.
REQ-017 Grant for requester i registers mem_addr <= addr_in slice i and asserts gnt[i] in the same cycle.
REQ-018 Latency: rd_valid[i] and rd_data = mem_q assert exactly 1 cycle after gnt[i]; in-flight tag register carries the index.
REQ-019 Round-robin: search starts at pointer+1 mod NREQ; after a grant to i, pointer <= i.
REQ-020 Fixed priority: lowest-index pending req wins; pointer not updated.
REQ-021 Lock: if last grantee j has req[j] and lock[j] high, j is granted again regardless of mode; pointer unchanged.
REQ-022 Lock release: dropping lock[j] or req[j] ends the lock; arbitration resumes next cycle under mode.
REQ-023 Requester must hold addr_in stable while req high and not yet granted; may deassert req the cycle after gnt.
REQ-024 Req held high after gnt is a new request; it competes normally (no implicit repeat without lock).
REQ-025 FSM states: IDLE (no in-flight read, no grant), ISSUE (grant issued this cycle), DRAIN (no new grant, previous read returning); IDLE->ISSUE on any req; ISSUE->ISSUE on any req; ISSUE->DRAIN when req==0; DRAIN->ISSUE on req; DRAIN->IDLE otherwise.
REQ-026 mode change takes effect on the next arbitration cycle; an in-flight read completes unaffected.
REQ-027 Pointer wraps NREQ-1 -> 0 modulo NREQ.
REQ-028 No req: gnt=0, mem_addr holds last value, rd_valid=0 the following cycle.

Reset
REQ-029 While reset low at a clock edge: gnt=0, rd_valid=0, rd_data=0, mem_addr=0, busy=0, pointer=NREQ-1 (so index 0 first), lock owner cleared, state IDLE.
REQ-030 A read launched the cycle before reset shall produce no rd_valid pulse.
REQ-031 First grant possible on the first edge with reset high.

Structure
REQ-032 Shared package holds NREQ/AW/DW defaults and the IDLE/ISSUE/DRAIN state encoding (one-hot, 3 bits).
REQ-033 One sub-module rr_arbiter: combinational rotating-priority selector (req, pointer, mode) -> one-hot winner; state, lock and tag logic stay in search_mem_arbiter.
REQ-034 Memory model in bench is memory_block (address, clock, q) with 1-cycle registered read.

Verification
REQ-035 After reset, req=4'b0001, addr_in[0]=5'd7 -> gnt=4'b0001 next edge, mem_addr=7, rd_valid=4'b0001 with rd_data=mem[7] one cycle later.
REQ-036 mode=0, req=4'b1111 held -> grant order 0,1,2,3,0, one per cycle, rd_valid follows each by 1 cycle.
REQ-037 mode=1, req=4'b1010 held -> gnt=4'b0010 every cycle; requester 3 never granted until req[1] drops.
REQ-038 mode=0, req=4'b0011, lock[1]=1 after first grant to 1 -> gnt=4'b0010 repeated; lock[1]=0 -> next grant to 0.
REQ-039 Reset low the cycle after gnt[2] -> no rd_valid pulse; after release req=4'b0100 -> gnt[2] granted first cycle.
REQ-040 req pulses end -> state ISSUE->DRAIN->IDLE, busy falls one cycle after last rd_valid edge.
